// File: rtl/nibble_slice_sched.sv
// nibble_slice_sched
// Shares one external SLICE-bit logic slice between two requesters.
// A round-robin arbiter picks one pending request, latches its operands and
// opcode, then walks the operands through the slice one nibble per cycle,
// least-significant nibble first. The assembled result is published together
// with a one-cycle done pulse that names the owner of the result.

module nibble_slice_sched #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req,
    input  logic [3:0]           op_in,
    input  logic [2*WIDTH-1:0]   a_in,
    input  logic [2*WIDTH-1:0]   b_in,
    output logic [1:0]           gnt,
    output logic [1:0]           slice_op,
    output logic [SLICE-1:0]     slice_a,
    output logic [SLICE-1:0]     slice_b,
    input  logic [SLICE-1:0]     slice_y,
    output logic                 busy,
    output logic [1:0]           done,
    output logic [WIDTH-1:0]     result,
    output logic                 zero
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int NSTEP  = WIDTH / SLICE;
    localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    // Operands that do not split into whole slices cannot be sequenced.
    if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_bad_width
        $error("nibble_slice_sched: WIDTH must be a non-zero multiple of SLICE");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_r;
    logic [STEP_W-1:0]      step_r;
    logic                   last_gnt_r;     // last granted requester, also owner of the running op
    logic                   gnt_seen_r;     // no grant since reset: tie goes to requester 0
    logic [1:0]             op_r;
    logic [WIDTH-1:0]       a_sh_r;         // latched A, shifted down one slice per step
    logic [WIDTH-1:0]       b_sh_r;         // latched B, shifted down one slice per step
    logic [WIDTH-1:0]       shadow_r;       // partial result being assembled
    logic [WIDTH-1:0]       result_r;
    logic                   zero_r;
    logic [1:0]             done_r;
    logic                   busy_r;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   grant_any_s;
    logic                   winner_s;
    logic [1:0]             gnt_s;
    logic [1:0]             op_win_s;
    logic [WIDTH-1:0]       a_win_s;
    logic [WIDTH-1:0]       b_win_s;
    logic [WIDTH-1:0]       shadow_next_s;
    logic                   last_step_s;

    // Round-robin arbitration: only evaluated in IDLE and outside reset.
    always_comb begin
        grant_any_s = 1'b0;
        winner_s    = 1'b0;
        if ((state_r == ST_IDLE) && !reset) begin
            case (req)
                2'b01: begin
                    grant_any_s = 1'b1;
                    winner_s    = 1'b0;
                end
                2'b10: begin
                    grant_any_s = 1'b1;
                    winner_s    = 1'b1;
                end
                2'b11: begin
                    grant_any_s = 1'b1;
                    winner_s    = gnt_seen_r ? ~last_gnt_r : 1'b0;
                end
                default: begin
                    grant_any_s = 1'b0;
                    winner_s    = 1'b0;
                end
            endcase
        end else begin
            grant_any_s = 1'b0;
            winner_s    = 1'b0;
        end
    end

    // One-hot grant pulse and operand mux for the winning requester.
    always_comb begin
        gnt_s    = 2'b00;
        op_win_s = op_in[1:0];
        a_win_s  = a_in[0 +: WIDTH];
        b_win_s  = b_in[0 +: WIDTH];
        if (grant_any_s) begin
            gnt_s = winner_s ? 2'b10 : 2'b01;
        end else begin
            gnt_s = 2'b00;
        end
        if (winner_s) begin
            op_win_s = op_in[3:2];
            a_win_s  = a_in[WIDTH +: WIDTH];
            b_win_s  = b_in[WIDTH +: WIDTH];
        end else begin
            op_win_s = op_in[1:0];
            a_win_s  = a_in[0 +: WIDTH];
            b_win_s  = b_in[0 +: WIDTH];
        end
    end

    // Merge the slice output into the nibble position of the current step.
    always_comb begin
        shadow_next_s = shadow_r;
        for (int s = 0; s < NSTEP; s++) begin
            if (step_r == STEP_W'(s)) begin
                shadow_next_s[s*SLICE +: SLICE] = slice_y;
            end else begin
                shadow_next_s[s*SLICE +: SLICE] = shadow_r[s*SLICE +: SLICE];
            end
        end
    end

    // Final step of the operation: the merged shadow becomes the result.
    always_comb begin
        last_step_s = 1'b0;
        if (step_r == STEP_W'(NSTEP - 1)) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
    end

    // Scheduler FSM: grant, nibble-serial run, one-cycle completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            step_r     <= {STEP_W{1'b0}};
            last_gnt_r <= 1'b0;
            gnt_seen_r <= 1'b0;
            op_r       <= 2'b00;
            a_sh_r     <= {WIDTH{1'b0}};
            b_sh_r     <= {WIDTH{1'b0}};
            shadow_r   <= {WIDTH{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            zero_r     <= 1'b1;
            done_r     <= 2'b00;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 2'b00;
                    if (grant_any_s) begin
                        op_r       <= op_win_s;
                        a_sh_r     <= a_win_s;
                        b_sh_r     <= b_win_s;
                        last_gnt_r <= winner_s;
                        gnt_seen_r <= 1'b1;
                        step_r     <= {STEP_W{1'b0}};
                        shadow_r   <= {WIDTH{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    shadow_r <= shadow_next_s;
                    a_sh_r   <= a_sh_r >> SLICE;
                    b_sh_r   <= b_sh_r >> SLICE;
                    if (last_step_s) begin
                        // Result and flag are taken from the merged value so the
                        // last nibble captured on this edge is included.
                        result_r <= shadow_next_s;
                        zero_r   <= (shadow_next_s == {WIDTH{1'b0}});
                        done_r   <= last_gnt_r ? 2'b10 : 2'b01;
                        step_r   <= {STEP_W{1'b0}};
                        state_r  <= ST_DONE;
                    end else begin
                        step_r  <= step_r + STEP_W'(1);
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 2'b00;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 2'b00;
                    busy_r  <= 1'b0;
                    step_r  <= {STEP_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Slice drive is decoded purely from registered state; idle slice sees zeros.
    always_comb begin
        slice_op = 2'b00;
        slice_a  = {SLICE{1'b0}};
        slice_b  = {SLICE{1'b0}};
        if (state_r == ST_RUN) begin
            slice_op = op_r;
            slice_a  = a_sh_r[SLICE-1:0];
            slice_b  = b_sh_r[SLICE-1:0];
        end else begin
            slice_op = 2'b00;
            slice_a  = {SLICE{1'b0}};
            slice_b  = {SLICE{1'b0}};
        end
    end

    // Output mapping.
    assign gnt    = gnt_s;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign zero   = zero_r;

endmodule

// File: tb/tb_nibble_slice_sched.sv
// Directed bench for nibble_slice_sched with a behavioural model of the
// external 4-bit logic slice. Expected values are hand-computed constants.
`timescale 1ns/1ps

module tb_nibble_slice_sched;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [3:0]  op_in;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [1:0]  gnt;
    logic [1:0]  slice_op;
    logic [3:0]  slice_a;
    logic [3:0]  slice_b;
    logic [3:0]  slice_y;
    logic        busy;
    logic [1:0]  done;
    logic [7:0]  result;
    logic        zero;

    int vectors;
    int miscompares;

    nibble_slice_sched #(.WIDTH(8), .SLICE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .op_in    (op_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .gnt      (gnt),
        .slice_op (slice_op),
        .slice_a  (slice_a),
        .slice_b  (slice_b),
        .slice_y  (slice_y),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External slice: combinational XOR/AND/OR/XNOR stage.
    always_comb begin
        case (slice_op)
            2'b00:   slice_y = slice_a ^ slice_b;
            2'b01:   slice_y = slice_a & slice_b;
            2'b10:   slice_y = slice_a | slice_b;
            default: slice_y = ~(slice_a ^ slice_b);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One full operation from IDLE for a single requester r (01 or 10).
    task automatic run_op(input logic [1:0] r, input logic [1:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_y, input logic [7:0] prev_y);
        req = r;
        if (r == 2'b01) begin
            op_in = {~op, op};
            a_in  = {~a, a};
            b_in  = {~b, b};
        end else begin
            op_in = {op, ~op};
            a_in  = {a, ~a};
            b_in  = {b, ~b};
        end
        #1;
        check("grant", gnt, r);
        check("result_held_at_grant", result, prev_y);
        check("idle_not_busy", busy, 1'b0);
        tick();
        req = 2'b00;
        #1;
        check("run1_busy", busy, 1'b1);
        check("run1_no_gnt", gnt, 2'b00);
        check("run1_slice_op", slice_op, op);
        check("run1_slice_a", slice_a, a[3:0]);
        check("run1_slice_b", slice_b, b[3:0]);
        tick();
        check("run2_slice_a", slice_a, a[7:4]);
        check("run2_slice_b", slice_b, b[7:4]);
        check("run2_no_done", done, 2'b00);
        tick();
        check("done_owner", done, r);
        check("done_result", result, exp_y);
        check("done_zero", zero, (exp_y == 8'h00));
        check("done_busy", busy, 1'b1);
        tick();
        check("after_done_clear", done, 2'b00);
        check("after_done_idle", busy, 1'b0);
        check("after_done_result", result, exp_y);
        check("after_done_slice_op", slice_op, 2'b00);
    endtask

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req         = 2'b00;
        op_in       = 4'h0;
        a_in        = 16'h0000;
        b_in        = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_gnt", gnt, 2'b00);
            check("rst_busy", busy, 1'b0);
            check("rst_result", result, 8'h00);
            check("rst_zero", zero, 1'b1);
            check("rst_done", done, 2'b00);
        end

        // Requester 0 XOR 0x5A ^ 0xFF = 0xA5
        run_op(2'b01, 2'b00, 8'h5A, 8'hFF, 8'hA5, 8'h00);
        // Requester 1 XOR 0x3C ^ 0x3C = 0x00 (zero flag)
        run_op(2'b10, 2'b00, 8'h3C, 8'h3C, 8'h00, 8'hA5);
        // AND 0xF0 & 0x3C = 0x30
        run_op(2'b10, 2'b01, 8'hF0, 8'h3C, 8'h30, 8'h00);
        // OR 0xF0 | 0x3C = 0xFC
        run_op(2'b10, 2'b10, 8'hF0, 8'h3C, 8'hFC, 8'h30);
        // XNOR 0x0F ~^ 0x33 = 0xC3
        run_op(2'b01, 2'b11, 8'h0F, 8'h33, 8'hC3, 8'hFC);

        // Both requesting continuously from reset: 01,10,01,10
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 2'b11;
        op_in = {2'b01, 2'b00};
        a_in  = {8'h44, 8'h11};
        b_in  = {8'h0F, 8'h22};
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("rr_run_no_gnt", gnt, 2'b00);
            tick();
            tick();
            check("rr_done_owner", done, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_done_no_gnt", gnt, 2'b00);
            check("rr_result", result, (k % 2 == 0) ? 8'h33 : 8'h04);
            tick();
        end
        req = 2'b00;

        // Reset during RUN step 1 aborts the 0x12 ^ 0x34 op
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 2'b01;
        op_in = {2'b11, 2'b00};
        a_in  = {8'hED, 8'h12};
        b_in  = {8'hCB, 8'h34};
        #1;
        check("abort_grant", gnt, 2'b01);
        tick();
        req = 2'b00;
        tick();
        check("abort_step1_slice_a", slice_a, 4'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 2'b00);
        check("abort_result", result, 8'h00);
        check("abort_zero", zero, 1'b1);
        check("abort_slice_a", slice_a, 4'h0);
        tick();
        check("abort_no_late_done", done, 2'b00);
        tick();
        check("abort_no_late_done2", done, 2'b00);
        run_op(2'b01, 2'b00, 8'h12, 8'h34, 8'h26, 8'h00);

        // Operands and req changed during RUN are ignored: 0x0F | 0xF0 = 0xFF
        req   = 2'b01;
        op_in = {2'b00, 2'b10};
        a_in  = {8'h00, 8'h0F};
        b_in  = {8'h00, 8'hF0};
        #1;
        check("late_grant", gnt, 2'b01);
        tick();
        req   = 2'b10;
        op_in = {2'b11, 2'b00};
        a_in  = {8'h55, 8'hAA};
        b_in  = {8'h33, 8'h00};
        #1;
        check("late_run_no_gnt", gnt, 2'b00);
        check("late_run_op", slice_op, 2'b10);
        tick();
        check("late_run2_no_gnt", gnt, 2'b00);
        tick();
        check("late_done_owner", done, 2'b01);
        check("late_result", result, 8'hFF);
        check("late_zero", zero, 1'b0);
        check("late_done_no_gnt", gnt, 2'b00);
        req = 2'b00;
        tick();
        check("late_idle_done", done, 2'b00);
        check("late_idle_gnt", gnt, 2'b00);
        check("late_idle_result", result, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
